// File: rtl/alu_issue_if.sv
// Issue-stage bus: upstream decode request and downstream ALU bundle with valid/ready.
interface alu_issue_if #(parameter int DATA_WIDTH = 32);
  logic                  in_valid;
  logic                  in_ready;
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [4:0]            shamt_in;
  logic [15:0]           imm;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            alu_operation;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [4:0]            shamt;
  logic                  illegal;

  modport slave (
    input  in_valid, opcode, funct, shamt_in, imm, rs_data, rt_data, out_ready,
    output in_ready, out_valid, alu_operation, a, b, shamt, illegal
  );
  modport master (
    output in_valid, opcode, funct, shamt_in, imm, rs_data, rt_data, out_ready,
    input  in_ready, out_valid, alu_operation, a, b, shamt, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// ALU issue stage: decodes MIPS-style ALU ops into a registered bundle.
// ALU_ISSUE_SKID_EN selects a 2-entry main+skid buffer with registered in_ready.
module alu_issue #(
  parameter int DATA_WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  input logic        flush,
  alu_issue_if.slave bus
);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_NOR = 4'b0010,
                         OP_ADD = 4'b0011, OP_SUB = 4'b0100, OP_SLL = 4'b0101,
                         OP_SRL = 4'b0110, OP_ILL = 4'b1111;

  typedef struct packed {
    logic [3:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [4:0]            shamt;
    logic                  illegal;
  } bundle_t;

  bundle_t               dec, main;
  logic                  main_valid, accept, pop;
  logic [DATA_WIDTH-1:0] sx, zx;

  assign sx = {{(DATA_WIDTH-16){bus.imm[15]}}, bus.imm};
  assign zx = {{(DATA_WIDTH-16){1'b0}}, bus.imm};

  always_comb begin
    dec = '{op: OP_ILL, a: '0, b: '0, shamt: 5'd0, illegal: 1'b1};
    case (bus.opcode)
      6'h00: case (bus.funct)
        6'h20: dec = '{OP_ADD, bus.rs_data, bus.rt_data, 5'd0, 1'b0};
        6'h22: dec = '{OP_SUB, bus.rs_data, bus.rt_data, 5'd0, 1'b0};
        6'h24: dec = '{OP_AND, bus.rs_data, bus.rt_data, 5'd0, 1'b0};
        6'h25: dec = '{OP_OR,  bus.rs_data, bus.rt_data, 5'd0, 1'b0};
        6'h27: dec = '{OP_NOR, bus.rs_data, bus.rt_data, 5'd0, 1'b0};
        6'h00: dec = '{OP_SLL, bus.rt_data, '0, bus.shamt_in, 1'b0};
        6'h02: dec = '{OP_SRL, bus.rt_data, '0, bus.shamt_in, 1'b0};
        default: ;
      endcase
      6'h08: dec = '{OP_ADD, bus.rs_data, sx, 5'd0, 1'b0};
      6'h0C: dec = '{OP_AND, bus.rs_data, zx, 5'd0, 1'b0};
      6'h0D: dec = '{OP_OR,  bus.rs_data, zx, 5'd0, 1'b0};
      // lui is realised as a shift of the zero-extended immediate by 16
      6'h0F: dec = '{OP_SLL, zx, '0, 5'd16, 1'b0};
      6'h04, 6'h05: dec = '{OP_SUB, bus.rs_data, bus.rt_data, 5'd0, 1'b0};
      default: ;
    endcase
  end

  assign accept = bus.in_valid & bus.in_ready & ~flush;
  assign pop    = main_valid & bus.out_ready;

`ifdef ALU_ISSUE_SKID_EN
  bundle_t skid;
  logic    skid_valid, rdy_q;

  assign bus.in_ready = rdy_q;

  // rdy_q tracks !skid_valid of the next state, so a new accept only lands
  // in the skid when main is stalled, and never when the skid is occupied.
  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main       <= '0;
      skid_valid <= 1'b0;
      skid       <= '0;
      rdy_q      <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      rdy_q      <= 1'b1;
    end else if (!main_valid || pop) begin
      rdy_q <= 1'b1;
      if (skid_valid) begin
        main       <= skid;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main <= dec;
      end
    end else if (accept) begin
      skid       <= dec;
      skid_valid <= 1'b1;
      rdy_q      <= 1'b0;
    end
  end
`else
  assign bus.in_ready = reset & (~main_valid | bus.out_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main       <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (accept) begin
      main       <= dec;
      main_valid <= 1'b1;
    end else if (pop) begin
      main_valid <= 1'b0;
    end
  end
`endif

  assign bus.out_valid     = main_valid;
  assign bus.alu_operation = main.op;
  assign bus.a             = main.a;
  assign bus.b             = main.b;
  assign bus.shamt         = main.shamt;
  assign bus.illegal       = main.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed and random steps against a queue-based model.
module tb_alu_issue;
  logic clk = 1'b0, reset = 1'b0, flush = 1'b0;
  alu_issue_if #(.DATA_WIDTH(32)) bus();
  alu_issue #(.DATA_WIDTH(32)) dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic        ill;
  } exp_t;

  exp_t q[$];
  bit   rdy_reg  = 1'b0;
  bit   zero_exp = 1'b1;
  int   nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_dec(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                   input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt);
    exp_t r;
    logic [31:0] sx, zx;
    sx = {{16{im[15]}}, im};
    zx = {16'h0000, im};
    r = '{4'hF, 32'd0, 32'd0, 5'd0, 1'b1};
    if (op == 6'h00) begin
      if      (fn == 6'h20) r = '{4'd3, rs, rt, 5'd0, 1'b0};
      else if (fn == 6'h22) r = '{4'd4, rs, rt, 5'd0, 1'b0};
      else if (fn == 6'h24) r = '{4'd0, rs, rt, 5'd0, 1'b0};
      else if (fn == 6'h25) r = '{4'd1, rs, rt, 5'd0, 1'b0};
      else if (fn == 6'h27) r = '{4'd2, rs, rt, 5'd0, 1'b0};
      else if (fn == 6'h00) r = '{4'd5, rt, 32'd0, sh, 1'b0};
      else if (fn == 6'h02) r = '{4'd6, rt, 32'd0, sh, 1'b0};
    end
    else if (op == 6'h08) r = '{4'd3, rs, sx, 5'd0, 1'b0};
    else if (op == 6'h0C) r = '{4'd0, rs, zx, 5'd0, 1'b0};
    else if (op == 6'h0D) r = '{4'd1, rs, zx, 5'd0, 1'b0};
    else if (op == 6'h0F) r = '{4'd5, zx, 32'd0, 5'd16, 1'b0};
    else if (op == 6'h04 || op == 6'h05) r = '{4'd4, rs, rt, 5'd0, 1'b0};
    return r;
  endfunction

  // One clock: drive, check pre-edge view against model, advance model at the edge.
  task automatic cyc(input bit iv, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                     input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt,
                     input bit orr, input bit fl, input bit rst);
    bit er, acc, pop;
    exp_t e;
    bus.in_valid = iv; bus.opcode = op; bus.funct = fn; bus.shamt_in = sh;
    bus.imm = im; bus.rs_data = rs; bus.rt_data = rt; bus.out_ready = orr;
    flush = fl; reset = rst;
    #1;
`ifdef ALU_ISSUE_SKID_EN
    er = rdy_reg;
`else
    er = rst && (q.size() == 0 || orr);
`endif
    chk("in_ready", 32'(bus.in_ready), 32'(er));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("alu_op", 32'(bus.alu_operation), 32'(q[0].op));
      chk("a", bus.a, q[0].a);
      chk("b", bus.b, q[0].b);
      chk("shamt", 32'(bus.shamt), 32'(q[0].sh));
      chk("illegal", 32'(bus.illegal), 32'(q[0].ill));
    end else if (zero_exp) begin
      chk("rst_op", 32'(bus.alu_operation), 32'd0);
      chk("rst_a", bus.a, 32'd0);
      chk("rst_b", bus.b, 32'd0);
      chk("rst_shamt", 32'(bus.shamt), 32'd0);
      chk("rst_illegal", 32'(bus.illegal), 32'd0);
    end
    acc = rst && !fl && iv && er;
    pop = q.size() > 0 && orr;
    e = ref_dec(op, fn, sh, im, rs, rt);
    @(posedge clk);
    if (!rst) begin
      q.delete(); rdy_reg = 1'b0; zero_exp = 1'b1;
    end else begin
      if (fl) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      rdy_reg = q.size() < 2; zero_exp = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input bit orr, input bit fl, input bit rst);
    cyc(1'b0, 6'h3F, 6'h3F, 5'd0, 16'h0, 32'h0, 32'h0, orr, fl, rst);
  endtask

  task automatic add(input logic [31:0] rs, input logic [31:0] rt, input bit orr, input bit fl);
    cyc(1'b1, 6'h00, 6'h20, 5'd0, 16'h0, rs, rt, orr, fl, 1'b1);
  endtask

  logic [5:0] ops [8];
  logic [5:0] fns [8];

  initial begin
    ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h05, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h20};
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    idle(1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b1);
    chk("ready_after_release", 32'(bus.in_ready), 32'd1);

    // addi with negative immediate
    cyc(1'b1, 6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd5, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_op", 32'(bus.alu_operation), 32'h3);
    chk("addi_b", bus.b, 32'hFFFF_FFFF);
    // lui
    cyc(1'b1, 6'h0F, 6'h00, 5'd0, 16'h1234, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0, 1'b1);
    chk("lui_a", bus.a, 32'h0000_1234);
    chk("lui_shamt", 32'(bus.shamt), 32'd16);
    // sll
    cyc(1'b1, 6'h00, 6'h00, 5'd4, 16'h0, 32'h77, 32'd1, 1'b1, 1'b0, 1'b1);
    chk("sll_a", bus.a, 32'd1);
    chk("sll_shamt", 32'(bus.shamt), 32'd4);
    // illegal opcode
    cyc(1'b1, 6'h3F, 6'h20, 5'd3, 16'h55, 32'h11, 32'h22, 1'b1, 1'b0, 1'b1);
    chk("ill_flag", 32'(bus.illegal), 32'd1);
    chk("ill_op", 32'(bus.alu_operation), 32'hF);
    chk("ill_a", bus.a, 32'd0);
    idle(1'b1, 1'b0, 1'b1);

    // back-to-back adds into a stalled consumer, then drain
    for (int i = 0; i < 4; i++) add(32'(i + 1), 32'(10 * i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0, 1'b1);

    // fill, then flush with an input offered in the same cycle
    add(32'h100, 32'h1, 1'b0, 1'b0);
    add(32'h200, 32'h2, 1'b0, 1'b0);
    add(32'h300, 32'h3, 1'b0, 1'b1);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_ready", 32'(bus.in_ready), 32'd1);
    idle(1'b1, 1'b0, 1'b1);

    // reset while a bundle is stalled at the output
    add(32'h400, 32'h4, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_ready", 32'(bus.in_ready), 32'd0);
    idle(1'b1, 1'b0, 1'b1);
    chk("rst_mid_release", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 600; i++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 7)];
      fn = fns[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      cyc($urandom_range(0, 3) != 0, op, fn, 5'($urandom), 16'($urandom), $urandom, $urandom,
          $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 99) != 0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  upstream holds a valid instruction.
REQ-005 in_ready  output  1  stage can accept an instruction this cycle.
REQ-006 opcode  input  6  instruction[31:26].
REQ-007 funct  input  6  instruction[5:0].
REQ-008 shamt_in  input  5  instruction[10:6].
REQ-009 imm  input  16  instruction[15:0].
REQ-010 rs_data  input  32  register-file read of rs.
REQ-011 rt_data  input  32  register-file read of rt.
REQ-012 flush  input  1  discard every held instruction.
REQ-013 out_valid  output  1  ALU-side bundle is valid.
REQ-014 out_ready  input  1  downstream consumes the bundle.
REQ-015 alu_operation  output  4  ALU opcode: AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, SLL 0101, SRL 0110.
REQ-016 a, b  output  32 each  ALU operands A, B.
REQ-017 shamt  output  5  ALU shift amount.
REQ-018 illegal  output  1  decoded instruction is unsupported.

Function
REQ-019 Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready; latency in-to-out exactly 1 cycle when empty.
REQ-020 R-type (opcode 0x00): funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR with a=rs_data, b=rt_data, shamt=0.
REQ-021 R-type funct 0x00 SLL, 0x02 SRL: a=rt_data, b=0, shamt=shamt_in.
REQ-022 addi 0x08: ADD, a=rs_data, b=sign-extended imm; andi 0x0C: AND, ori 0x0D: OR, both b=zero-extended imm.
REQ-023 lui 0x0F: SLL, a=zero-extended imm, b=0, shamt=16.
REQ-024 beq 0x04, bne 0x05: SUB, a=rs_data, b=rt_data.
REQ-025 Any other opcode/funct: alu_operation=4'b1111, a=b=0, shamt=0, illegal=1; still issued as a normal bundle.
REQ-026 Decoded bundle captured in registers; outputs are registered, never combinational from inputs.
REQ-027 Bundle held stable while out_valid&!out_ready.
REQ-028 flush: next cycle all entries invalid, out_valid=0; flush beats in_valid in the same cycle (input dropped).
REQ-029 Simultaneous in and out transfer when full-throughput path allows: no bubble, order preserved.

Reset
REQ-030 reset=0 at an edge: out_valid=0, skid entry invalid, alu_operation=0, a=b=0, shamt=0, illegal=0.
REQ-031 in_ready=0 while reset=0; in_ready=1 first cycle after release.
REQ-032 Reset mid-transfer discards held bundles; no partial output afterwards.

Configuration
REQ-033 Macro ALU_ISSUE_SKID_EN defined: 2-entry (main+skid) buffer; in_ready is a register = !skid_valid; sustains 1 instr/cycle with registered ready; stall fills skid, out_ready release drains skid into main next cycle.
REQ-034 Macro undefined: single entry; in_ready = !out_valid | out_ready (combinational); identical decode and ordering.

Verification
REQ-035 addi opcode 0x08, rs_data=5, imm=0xFFFF, out_ready=1 -> next cycle out_valid=1, alu_operation=0011, a=5, b=0xFFFFFFFF, illegal=0.
REQ-036 lui imm=0x1234 -> alu_operation=0101, a=0x00001234, shamt=16; sll funct 0x00 rt_data=1 shamt_in=4 -> a=1, shamt=4.
REQ-037 opcode 0x3F -> alu_operation=1111, illegal=1, a=b=0, out_valid=1.
REQ-038 Three back-to-back adds, out_ready=0 for 3 cycles then 1 -> with SKID_EN: in_ready falls after 2 accepted, outputs in order, none lost/duplicated; without: in_ready falls after 1.
REQ-039 Two entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no output from any of the three.
REQ-040 reset=0 asserted while out_valid=1, out_ready=0 -> next cycle all outputs 0, in_ready=0; release -> in_ready=1.
